// File: rtl/mem_store_buffer.sv
// mem_store_buffer: posted-write buffer between the EXE/MEM register and the
// MEM stage. Stores enter a small FIFO in one cycle and drain in the
// background. Loads are forwarded from the buffer when they hit. Loads that
// miss are issued to MEM ahead of queued stores. The pipeline is frozen while
// a load miss or a store into a full buffer is outstanding.
module mem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             MEM_R_EN,
  input  logic             MEM_W_EN,
  input  logic [31:0]      Address,
  input  logic [31:0]      Data,
  output logic             mem_r_en,
  output logic             mem_w_en,
  output logic [31:0]      mem_address,
  output logic [31:0]      mem_data,
  input  logic             mem_ready,
  input  logic [31:0]      mem_result,
  output logic [31:0]      load_data,
  output logic             freeze,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_MAX = (PTR_W+1)'(DEPTH);

  // FIFO storage: word address, data and a valid bit per entry
  logic [DEPTH-1:0][29:0] addr_q, addr_d;
  logic [DEPTH-1:0][31:0] data_q, data_d;
  logic [DEPTH-1:0]       valid_q, valid_d;
  logic [PTR_W-1:0]       head_q, head_d;
  logic [PTR_W-1:0]       tail_q, tail_d;
  logic [PTR_W:0]         count_q, count_d;
  logic                   empty_q, empty_d;

  // Controller state and registered MEM-side outputs
  state_e                 state_q, state_d;
  logic                   mem_r_en_q, mem_r_en_d;
  logic                   mem_w_en_q, mem_w_en_d;
  logic [31:0]            mem_address_q, mem_address_d;
  logic [31:0]            mem_data_q, mem_data_d;

  // Combinational helpers
  logic                   hit_s;
  logic [31:0]            fwd_data_s;
  logic [PTR_W-1:0]       scan_idx_s;
  logic [PTR_W-1:0]       nxt_idx_s;
  logic                   full_s;
  logic                   pop_s;
  logic                   push_s;
  logic                   ld_miss_s;
  logic                   ld_done_s;

  // Scan the buffer oldest-to-youngest so the youngest matching store wins
  always_comb begin
    hit_s      = 1'b0;
    fwd_data_s = 32'd0;
    scan_idx_s = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx_s = head_q + PTR_W'(i);
      if (valid_q[scan_idx_s] && (addr_q[scan_idx_s] == Address[31:2])) begin
        hit_s      = 1'b1;
        fwd_data_s = data_q[scan_idx_s];
      end else begin
        hit_s      = hit_s;
        fwd_data_s = fwd_data_s;
      end
    end
  end

  // Handshake qualifiers, pipeline freeze and load result selection
  always_comb begin
    full_s    = (count_q == CNT_MAX);
    pop_s     = (state_q == S_DRAIN) && mem_ready;
    push_s    = MEM_W_EN && (!full_s || pop_s);
    ld_miss_s = MEM_R_EN && !hit_s;
    ld_done_s = (state_q == S_LOAD) && mem_ready;
    freeze    = (MEM_W_EN && full_s && !pop_s) || (ld_miss_s && !ld_done_s);
    if (hit_s) begin
      load_data = fwd_data_s;
    end else begin
      load_data = mem_result;
    end
  end

  // FIFO bookkeeping: a slot freed by pop can be refilled by push in the same cycle
  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (pop_s) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_ONE;
    end else begin
      head_d          = head_q;
    end
    if (push_s) begin
      addr_d[tail_q]  = Address[31:2];
      data_d[tail_q]  = Data;
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + PTR_ONE;
    end else begin
      tail_d          = tail_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    empty_d   = (count_d == '0);
    nxt_idx_s = head_q + PTR_ONE;
  end

  // Controller: a pending load miss outranks queued stores, but an in-flight
  // store always runs to completion. The next head is read from the
  // post-update FIFO image so a store pushed this cycle can follow directly.
  always_comb begin
    state_d       = state_q;
    mem_r_en_d    = mem_r_en_q;
    mem_w_en_d    = mem_w_en_q;
    mem_address_d = mem_address_q;
    mem_data_d    = mem_data_q;
    case (state_q)
      S_IDLE: begin
        if (ld_miss_s) begin
          state_d       = S_LOAD;
          mem_r_en_d    = 1'b1;
          mem_w_en_d    = 1'b0;
          mem_address_d = Address;
        end else if (count_q != '0) begin
          state_d       = S_DRAIN;
          mem_r_en_d    = 1'b0;
          mem_w_en_d    = 1'b1;
          mem_address_d = {addr_q[head_q], 2'b00};
          mem_data_d    = data_q[head_q];
        end else begin
          state_d       = S_IDLE;
          mem_r_en_d    = 1'b0;
          mem_w_en_d    = 1'b0;
        end
      end
      S_LOAD: begin
        if (mem_ready) begin
          state_d    = S_IDLE;
          mem_r_en_d = 1'b0;
          mem_w_en_d = 1'b0;
        end else begin
          state_d    = S_LOAD;
        end
      end
      S_DRAIN: begin
        if (mem_ready) begin
          if (ld_miss_s) begin
            state_d       = S_LOAD;
            mem_r_en_d    = 1'b1;
            mem_w_en_d    = 1'b0;
            mem_address_d = Address;
          end else if (count_d != '0) begin
            state_d       = S_DRAIN;
            mem_r_en_d    = 1'b0;
            mem_w_en_d    = 1'b1;
            mem_address_d = {addr_d[nxt_idx_s], 2'b00};
            mem_data_d    = data_d[nxt_idx_s];
          end else begin
            state_d       = S_IDLE;
            mem_r_en_d    = 1'b0;
            mem_w_en_d    = 1'b0;
          end
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d    = S_IDLE;
        mem_r_en_d = 1'b0;
        mem_w_en_d = 1'b0;
      end
    endcase
  end

  // State register; reset abandons any in-flight MEM operation
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      addr_q        <= '0;
      data_q        <= '0;
      valid_q       <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      empty_q       <= 1'b1;
      state_q       <= S_IDLE;
      mem_r_en_q    <= 1'b0;
      mem_w_en_q    <= 1'b0;
      mem_address_q <= 32'd0;
      mem_data_q    <= 32'd0;
    end else begin
      addr_q        <= addr_d;
      data_q        <= data_d;
      valid_q       <= valid_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      empty_q       <= empty_d;
      state_q       <= state_d;
      mem_r_en_q    <= mem_r_en_d;
      mem_w_en_q    <= mem_w_en_d;
      mem_address_q <= mem_address_d;
      mem_data_q    <= mem_data_d;
    end
  end

  assign mem_r_en    = mem_r_en_q;
  assign mem_w_en    = mem_w_en_q;
  assign mem_address = mem_address_q;
  assign mem_data    = mem_data_q;
  assign count       = count_q;
  assign empty       = empty_q;

endmodule

// File: tb/tb_mem_store_buffer.sv
// Testbench for mem_store_buffer: directed scenarios followed by randomized
// traffic, checked against a queue-based model of the store buffer, an
// architectural memory image (program-order store results) and a backing
// memory image (stores that have actually reached MEM).
module tb_mem_store_buffer;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic             CLK;
  logic             RST;
  logic             MEM_R_EN;
  logic             MEM_W_EN;
  logic [31:0]      Address;
  logic [31:0]      Data;
  logic             mem_r_en;
  logic             mem_w_en;
  logic [31:0]      mem_address;
  logic [31:0]      mem_data;
  logic             mem_ready;
  logic [31:0]      mem_result;
  logic [31:0]      load_data;
  logic             freeze;
  logic             empty;
  logic [PTR_W:0]   count;

  mem_store_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .CLK(CLK), .RST(RST), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .Address(Address), .Data(Data), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .mem_address(mem_address), .mem_data(mem_data), .mem_ready(mem_ready),
    .mem_result(mem_result), .load_data(load_data), .freeze(freeze),
    .empty(empty), .count(count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [29:0] a;
    logic [31:0] d;
  } st_t;

  st_t         sq[$];
  logic [31:0] dram [logic [29:0]];
  logic [31:0] arch [logic [29:0]];

  int          checks   = 0;
  int          failures = 0;
  int          fixed_lat = -1;
  bit          hold_ready = 1'b0;
  bit          pulse_ready = 1'b0;
  bit          in_op = 1'b0;
  int          wait_cnt = 0;
  bit          prio_exp = 1'b0;
  int          frz_cnt = 0;
  bit          accepted = 1'b0;
  logic [31:0] last_ld = 32'd0;
  logic        last_rd_en = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_val(input logic [29:0] w);
    return {w, 2'b11} ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] dram_rd(input logic [29:0] w);
    if (dram.exists(w)) return dram[w];
    else return init_val(w);
  endfunction

  function automatic logic [31:0] arch_rd(input logic [29:0] w);
    if (arch.exists(w)) return arch[w];
    else return init_val(w);
  endfunction

  function automatic bit in_queue(input logic [29:0] w);
    foreach (sq[i]) if (sq[i].a == w) return 1'b1;
    return 1'b0;
  endfunction

  // MEM-stage responder: picks a latency per operation, drives mem_ready/mem_result
  task automatic respond();
    if (mem_ready) in_op = 1'b0;
    if (mem_r_en || mem_w_en) begin
      if (!in_op) begin
        in_op    = 1'b1;
        wait_cnt = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
      end else if (wait_cnt > 0) begin
        wait_cnt--;
      end
      mem_ready  = ((wait_cnt == 0) && !hold_ready) || pulse_ready;
      mem_result = mem_r_en ? dram_rd(mem_address[31:2]) : $urandom;
    end else begin
      mem_ready  = 1'b0;
      in_op      = 1'b0;
      mem_result = $urandom;
    end
  endtask

  // One clock cycle: check at negedge, update model at posedge, respond at posedge+1
  task automatic cycle();
    bit inq, wr_done, rd_done, exp_frz;
    @(negedge CLK);
    inq     = in_queue(Address[31:2]);
    wr_done = mem_w_en && mem_ready;
    rd_done = mem_r_en && mem_ready;
    exp_frz = (MEM_W_EN && sq.size() == DEPTH && !wr_done) ||
              (MEM_R_EN && !inq && !rd_done);
    if (prio_exp) check_eq("ld_prio", {31'd0, mem_r_en}, 32'd1);
    prio_exp = MEM_R_EN && !inq && !rd_done && ((!mem_r_en && !mem_w_en) || wr_done);
    check_eq("freeze", {31'd0, freeze}, {31'd0, exp_frz});
    check_eq("count", {29'd0, count}, sq.size());
    check_eq("empty", {31'd0, empty}, {31'd0, sq.size() == 0});
    if (mem_w_en) begin
      if (sq.size() == 0) begin
        check_eq("wr_unexpected", {31'd0, mem_w_en}, 32'd0);
      end else begin
        check_eq("wr_addr", {2'b00, mem_address[31:2]}, {2'b00, sq[0].a});
        check_eq("wr_data", mem_data, sq[0].d);
      end
    end
    if (mem_r_en) begin
      check_eq("rd_req", {31'd0, MEM_R_EN}, 32'd1);
      check_eq("rd_addr", {2'b00, mem_address[31:2]}, {2'b00, Address[31:2]});
    end
    if (MEM_R_EN && !exp_frz) begin
      check_eq("ld_data", load_data, arch_rd(Address[31:2]));
      last_ld    = load_data;
      last_rd_en = mem_r_en;
    end
    if (freeze) frz_cnt++;
    @(posedge CLK);
    if (wr_done && sq.size() > 0) begin
      dram[sq[0].a] = sq[0].d;
      sq.delete(0);
    end
    if (MEM_W_EN && !exp_frz) begin
      st_t e;
      e.a = Address[31:2];
      e.d = Data;
      sq.push_back(e);
      arch[Address[31:2]] = Data;
    end
    accepted = (MEM_R_EN || MEM_W_EN) && !exp_frz;
    #1;
    respond();
  endtask

  task automatic run_op(input bit is_st, input logic [31:0] a, input logic [31:0] d);
    MEM_W_EN = is_st;
    MEM_R_EN = !is_st;
    Address  = a;
    Data     = d;
    accepted = 1'b0;
    for (int n = 0; n < 60 && !accepted; n++) cycle();
    check_eq("op_done", {31'd0, accepted}, 32'd1);
  endtask

  task automatic idle(input int n);
    MEM_R_EN = 1'b0;
    MEM_W_EN = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic drain();
    int n;
    MEM_R_EN = 1'b0;
    MEM_W_EN = 1'b0;
    n = 0;
    while ((sq.size() != 0 || mem_w_en) && n < 200) begin
      cycle();
      n++;
    end
    check_eq("drain_done", sq.size(), 32'd0);
    check_eq("drain_empty", {31'd0, empty}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b0; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
    Address = 32'd0; Data = 32'd0; mem_ready = 1'b0; mem_result = 32'd0;
    repeat (2) @(posedge CLK);
    #1;
    check_eq("rst_r_en", {31'd0, mem_r_en}, 32'd0);
    check_eq("rst_w_en", {31'd0, mem_w_en}, 32'd0);
    check_eq("rst_addr", mem_address, 32'd0);
    check_eq("rst_data", mem_data, 32'd0);
    check_eq("rst_empty", {31'd0, empty}, 32'd1);
    check_eq("rst_count", {29'd0, count}, 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;

    // Back-to-back stores with a 4-cycle MEM, no freeze expected
    fixed_lat = 3;
    frz_cnt   = 0;
    run_op(1'b1, 32'h0000_0100, 32'hAAAA_0001);
    run_op(1'b1, 32'h0000_0104, 32'hAAAA_0002);
    drain();
    check_eq("t2_no_freeze", frz_cnt, 32'd0);
    check_eq("t2_mem_100", dram_rd(30'h40), 32'hAAAA_0001);
    check_eq("t2_mem_104", dram_rd(30'h41), 32'hAAAA_0002);

    // Youngest-store forwarding with a sub-word load address
    hold_ready = 1'b1;
    run_op(1'b1, 32'h0000_0200, 32'h0000_0011);
    run_op(1'b1, 32'h0000_0200, 32'h0000_0022);
    run_op(1'b0, 32'h0000_0202, 32'd0);
    check_eq("t3_fwd_data", last_ld, 32'h0000_0022);
    check_eq("t3_fwd_no_rd", {31'd0, last_rd_en}, 32'd0);
    hold_ready = 1'b0;
    drain();

    // Full buffer: fifth store freezes, then push and pop in one cycle
    hold_ready = 1'b1;
    for (int i = 0; i < 4; i++) run_op(1'b1, 32'h0000_0500 + 32'(i * 4), 32'h5000_0000 + 32'(i));
    MEM_W_EN = 1'b1; MEM_R_EN = 1'b0; Address = 32'h0000_0510; Data = 32'h5000_0004;
    cycle();
    check_eq("t4_full_freeze", {31'd0, freeze}, 32'd1);
    pulse_ready = 1'b1;
    cycle();
    pulse_ready = 1'b0;
    cycle();
    check_eq("t4_push_pop", {31'd0, accepted}, 32'd1);
    MEM_W_EN = 1'b0;
    cycle();
    check_eq("t4_count_kept", {29'd0, count}, 32'd4);
    hold_ready = 1'b0;
    drain();

    // Load miss behind an in-flight store is issued before the remaining stores
    fixed_lat = 3;
    dram[30'hC0] = 32'hDEAD_BEEF;
    arch[30'hC0] = 32'hDEAD_BEEF;
    run_op(1'b1, 32'h0000_0100, 32'h1111_0001);
    run_op(1'b1, 32'h0000_0104, 32'h1111_0002);
    run_op(1'b1, 32'h0000_0108, 32'h1111_0003);
    run_op(1'b0, 32'h0000_0300, 32'd0);
    check_eq("t5_ld_data", last_ld, 32'hDEAD_BEEF);
    check_eq("t5_stores_left", {29'd0, count}, 32'd2);
    drain();

    // Load miss on an empty buffer, MEM answers one cycle after issue
    fixed_lat = 1;
    frz_cnt   = 0;
    run_op(1'b0, 32'h0000_0404, 32'd0);
    check_eq("t6_freeze_cycles", frz_cnt, 32'd2);
    check_eq("t6_idle_r_en", {31'd0, mem_r_en}, 32'd0);
    idle(1);

    // Asynchronous reset in the middle of a drain
    hold_ready = 1'b1;
    for (int i = 0; i < 3; i++) run_op(1'b1, 32'h0000_0600 + 32'(i * 4), 32'h6000_0000 + 32'(i));
    idle(2);
    check_eq("t7_pre_count", {29'd0, count}, 32'd3);
    @(negedge CLK);
    #2;
    RST = 1'b0;
    #1;
    check_eq("t7_rst_w_en", {31'd0, mem_w_en}, 32'd0);
    check_eq("t7_rst_count", {29'd0, count}, 32'd0);
    check_eq("t7_rst_empty", {31'd0, empty}, 32'd1);
    sq.delete();
    arch = dram;
    mem_ready = 1'b0; in_op = 1'b0; prio_exp = 1'b0; hold_ready = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    idle(8);

    // Randomized traffic over a small address pool to provoke hits
    fixed_lat = -1;
    for (int k = 0; k < 800; k++) begin
      int r;
      logic [31:0] a;
      r = int'($urandom_range(0, 9));
      a = 32'h0000_0100 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
      if (r < 4) begin
        run_op(1'b1, a, $urandom);
      end else if (r < 7) begin
        if ($urandom_range(0, 3) == 0) a = a + 32'h0000_0800;
        run_op(1'b0, a, $urandom);
      end else begin
        idle(1);
      end
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
